// File: rtl/ysyx_23060124_ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_23060124_ifu_pkg
// Brief   : Shared constants and state encoding for the instruction fetch unit
// Revision: 1.0 - initial release
// ============================================================================
package ysyx_23060124_ifu_pkg;

   // PC loaded at reset unless the top-level parameter overrides it
   localparam logic [31:0] C_RESET_PC = 32'h3000_0000;

   // Canonical RISC-V NOP (addi x0, x0, 0) shown downstream before any fetch
   localparam logic [31:0] C_NOP_INS = 32'h0000_0013;

   // AXI read response encodings
   localparam logic [1:0] C_RESP_OKAY   = 2'b00;
   localparam logic [1:0] C_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] C_RESP_SLVERR = 2'b10;
   localparam logic [1:0] C_RESP_DECERR = 2'b11;

   // Fetch FSM states
   typedef enum logic [1:0] {
      IFU_IDLE = 2'd0,
      IFU_AR   = 2'd1,
      IFU_R    = 2'd2,
      IFU_HOLD = 2'd3
   } ifu_state_e;

endpackage : ysyx_23060124_ifu_pkg
`default_nettype wire

// File: rtl/ysyx_23060124_ifu.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_23060124_ifu
// Brief   : Instruction fetch unit. Holds the PC, fetches one instruction per
//           AXI4-Lite read and hands it to decode over valid/ready. Redirects
//           from later stages flush any in-flight read.
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_23060124_ifu
   import ysyx_23060124_ifu_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(C_RESET_PC)
) (
   input  logic              clock,
   input  logic              reset,
   // AXI4-Lite read address channel
   output logic [ADDR_W-1:0] o_araddr,
   output logic              o_arvalid,
   input  logic              i_arready,
   // AXI4-Lite read data channel
   input  logic [31:0]       i_rdata,
   input  logic [1:0]        i_rresp,
   input  logic              i_rvalid,
   output logic              o_rready,
   // Redirect from later stages
   input  logic              i_redirect_valid,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   // Downstream to decode
   output logic [31:0]       o_ins,
   output logic [ADDR_W-1:0] o_pc,
   output logic              o_fault,
   output logic              o_post_valid,
   input  logic              i_post_ready
);

   ifu_state_e        state_q,      state_d;
   logic [ADDR_W-1:0] pc_q,         pc_d;
   logic [ADDR_W-1:0] pc_pending_q, pc_pending_d;
   logic              flush_q,      flush_d;
   logic [31:0]       ins_q,        ins_d;
   logic [ADDR_W-1:0] ins_pc_q,     ins_pc_d;
   logic              fault_q,      fault_d;
   logic              arvalid_q,    arvalid_d;
   logic              rready_q,     rready_d;
   logic              post_valid_q, post_valid_d;

   logic              ar_hs;
   logic              r_hs;
   logic              post_hs;

   assign ar_hs   = arvalid_q & i_arready;
   assign r_hs    = rready_q & i_rvalid;
   assign post_hs = post_valid_q & i_post_ready;

   // Next-state, PC and output-latch logic; outputs are derived from the
   // next state so every bus/handshake output comes straight from a flop.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pc_pending_d = pc_pending_q;
      flush_d      = flush_q;
      ins_d        = ins_q;
      ins_pc_d     = ins_pc_q;
      fault_d      = fault_q;

      case (state_q)
         IFU_IDLE: begin
            if (i_redirect_valid) begin
               pc_d = i_redirect_pc;
            end
            state_d = IFU_AR;
         end

         IFU_AR: begin
            // araddr must stay stable until accepted, so a redirect here is
            // parked and the in-flight read is marked for discard.
            if (i_redirect_valid) begin
               pc_pending_d = i_redirect_pc;
               flush_d      = 1'b1;
            end
            if (ar_hs) begin
               state_d = IFU_R;
            end
         end

         IFU_R: begin
            if (r_hs) begin
               if (flush_q || i_redirect_valid) begin
                  // Wrong-path data: drop it and restart at the newest target
                  flush_d = 1'b0;
                  pc_d    = i_redirect_valid ? i_redirect_pc : pc_pending_q;
                  state_d = IFU_AR;
               end else begin
                  ins_d    = i_rdata;
                  ins_pc_d = pc_q;
                  fault_d  = (i_rresp != C_RESP_OKAY);
                  state_d  = IFU_HOLD;
               end
            end else if (i_redirect_valid) begin
               pc_pending_d = i_redirect_pc;
               flush_d      = 1'b1;
            end
         end

         IFU_HOLD: begin
            // Redirect wins over a simultaneous decode handshake
            if (i_redirect_valid) begin
               pc_d    = i_redirect_pc;
               state_d = IFU_AR;
            end else if (post_hs) begin
               pc_d    = pc_q + ADDR_W'(4);
               state_d = IFU_AR;
            end
         end

         default: begin
            state_d = IFU_IDLE;
         end
      endcase

      arvalid_d    = (state_d == IFU_AR);
      rready_d     = (state_d == IFU_R);
      post_valid_d = (state_d == IFU_HOLD);
   end

   // State and output registers with asynchronous active-low reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IFU_IDLE;
         pc_q         <= RESET_PC;
         pc_pending_q <= RESET_PC;
         flush_q      <= 1'b0;
         ins_q        <= C_NOP_INS;
         ins_pc_q     <= RESET_PC;
         fault_q      <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         post_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pc_pending_q <= pc_pending_d;
         flush_q      <= flush_d;
         ins_q        <= ins_d;
         ins_pc_q     <= ins_pc_d;
         fault_q      <= fault_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         post_valid_q <= post_valid_d;
      end
   end

   assign o_araddr     = pc_q;
   assign o_arvalid    = arvalid_q;
   assign o_rready     = rready_q;
   assign o_ins        = ins_q;
   assign o_pc         = ins_pc_q;
   assign o_fault      = fault_q;
   assign o_post_valid = post_valid_q;

endmodule : ysyx_23060124_ifu
`default_nettype wire

// File: tb/tb_ysyx_23060124_ifu.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_23060124_ifu
// Brief   : Directed self-checking bench for the instruction fetch unit
// Revision: 1.0 - initial release
// ============================================================================
module tb_ysyx_23060124_ifu;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] o_araddr;
   logic        o_arvalid;
   logic        i_arready = 1'b0;
   logic [31:0] i_rdata = 32'h0;
   logic [1:0]  i_rresp = 2'b00;
   logic        i_rvalid = 1'b0;
   logic        o_rready;
   logic        i_redirect_valid = 1'b0;
   logic [31:0] i_redirect_pc = 32'h0;
   logic [31:0] o_ins;
   logic [31:0] o_pc;
   logic        o_fault;
   logic        o_post_valid;
   logic        i_post_ready = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;

   ysyx_23060124_ifu dut (
      .clock            (clock),
      .reset            (reset),
      .o_araddr         (o_araddr),
      .o_arvalid        (o_arvalid),
      .i_arready        (i_arready),
      .i_rdata          (i_rdata),
      .i_rresp          (i_rresp),
      .i_rvalid         (i_rvalid),
      .o_rready         (o_rready),
      .i_redirect_valid (i_redirect_valid),
      .i_redirect_pc    (i_redirect_pc),
      .o_ins            (o_ins),
      .o_pc             (o_pc),
      .o_fault          (o_fault),
      .o_post_valid     (o_post_valid),
      .i_post_ready     (i_post_ready)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_ar(input string tag, input logic [31:0] exp);
      int n = 0;
      while (!o_arvalid && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_arvalid"}, {31'h0, o_arvalid}, 32'h1);
      check({tag, "_araddr"}, o_araddr, exp);
   endtask

   task automatic ar_hs();
      i_arready = 1'b1;
      tick();
      i_arready = 1'b0;
   endtask

   task automatic r_hs(input int lat, input logic [31:0] data, input logic [1:0] resp);
      int n = 0;
      repeat (lat) tick();
      while (!o_rready && n < 20) begin
         tick();
         n++;
      end
      check("rready", {31'h0, o_rready}, 32'h1);
      i_rvalid = 1'b1;
      i_rdata  = data;
      i_rresp  = resp;
      tick();
      i_rvalid = 1'b0;
      i_rdata  = 32'h0;
      i_rresp  = 2'b00;
   endtask

   task automatic post_chk(input string tag, input logic [31:0] ins,
                           input logic [31:0] pc, input logic fault);
      check({tag, "_pvalid"}, {31'h0, o_post_valid}, 32'h1);
      check({tag, "_ins"}, o_ins, ins);
      check({tag, "_pc"}, o_pc, pc);
      check({tag, "_fault"}, {31'h0, o_fault}, {31'h0, fault});
   endtask

   task automatic post_hs();
      i_post_ready = 1'b1;
      tick();
      i_post_ready = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] target);
      i_redirect_valid = 1'b1;
      i_redirect_pc    = target;
      tick();
      i_redirect_valid = 1'b0;
   endtask

   task automatic reset_chk(input string tag);
      check({tag, "_arvalid"}, {31'h0, o_arvalid}, 32'h0);
      check({tag, "_rready"}, {31'h0, o_rready}, 32'h0);
      check({tag, "_pvalid"}, {31'h0, o_post_valid}, 32'h0);
      check({tag, "_ins"}, o_ins, 32'h0000_0013);
      check({tag, "_pc"}, o_pc, 32'h3000_0000);
      check({tag, "_fault"}, {31'h0, o_fault}, 32'h0);
      check({tag, "_araddr"}, o_araddr, 32'h3000_0000);
   endtask

   initial begin
      // Reset state and first-fetch latency
      repeat (3) @(posedge clock);
      #1;
      reset_chk("rst");
      reset = 1'b1;
      check("idle_arvalid", {31'h0, o_arvalid}, 32'h0);
      tick();
      check("first_ar_lat", {31'h0, o_arvalid}, 32'h1);

      // Basic fetch, memory answers after 2 cycles, decode ready
      wait_ar("f0", 32'h3000_0000);
      ar_hs();
      r_hs(2, 32'h0000_0413, 2'b00);
      post_chk("f0", 32'h0000_0413, 32'h3000_0000, 1'b0);
      post_hs();
      check("f0_pvalid_drop", {31'h0, o_post_valid}, 32'h0);
      check("f1_ar_next", {31'h0, o_arvalid}, 32'h1);
      check("f1_addr", o_araddr, 32'h3000_0004);

      // Decode stalls for 5 cycles
      ar_hs();
      r_hs(1, 32'h0010_0093, 2'b00);
      for (int i = 0; i < 5; i++) begin
         post_chk("stall", 32'h0010_0093, 32'h3000_0004, 1'b0);
         check("stall_noar", {31'h0, o_arvalid}, 32'h0);
         tick();
      end
      post_hs();

      // Redirect while in R: returned data is dropped
      wait_ar("f2", 32'h3000_0008);
      ar_hs();
      redirect(32'h3000_0100);
      r_hs(0, 32'hBAD0_0001, 2'b00);
      check("rd_r_nopost", {31'h0, o_post_valid}, 32'h0);
      wait_ar("rd_r", 32'h3000_0100);
      ar_hs();
      r_hs(0, 32'h0000_0513, 2'b00);
      post_chk("rd_r_tgt", 32'h0000_0513, 32'h3000_0100, 1'b0);
      post_hs();

      // Redirect while in AR with arready held low for 3 cycles
      wait_ar("f3", 32'h3000_0104);
      redirect(32'h8000_0000);
      check("rd_ar_hold0", o_araddr, 32'h3000_0104);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rd_ar_hold_v", {31'h0, o_arvalid}, 32'h1);
         check("rd_ar_hold_a", o_araddr, 32'h3000_0104);
      end
      ar_hs();
      r_hs(1, 32'hBAD0_0002, 2'b00);
      check("rd_ar_nopost", {31'h0, o_post_valid}, 32'h0);
      wait_ar("rd_ar", 32'h8000_0000);

      // Error response is forwarded with fault, following fetch is clean
      ar_hs();
      r_hs(0, 32'hDEAD_BEEF, 2'b10);
      post_chk("err", 32'hDEAD_BEEF, 32'h8000_0000, 1'b1);
      post_hs();
      wait_ar("err_next", 32'h8000_0004);
      ar_hs();
      r_hs(0, 32'h0000_0613, 2'b00);
      post_chk("err_next", 32'h0000_0613, 32'h8000_0004, 1'b0);

      // Redirect in HOLD together with decode ready: redirect wins
      i_post_ready = 1'b1;
      redirect(32'hFFFF_FFFC);
      i_post_ready = 1'b0;
      check("rd_hold_pvalid", {31'h0, o_post_valid}, 32'h0);
      wait_ar("rd_hold", 32'hFFFF_FFFC);

      // PC wrap at the top of the address space
      ar_hs();
      r_hs(1, 32'h0000_0073, 2'b00);
      post_chk("wrap", 32'h0000_0073, 32'hFFFF_FFFC, 1'b0);
      post_hs();
      wait_ar("wrap_next", 32'h0000_0000);

      // Asynchronous reset while in R
      ar_hs();
      check("pre_rst_rready", {31'h0, o_rready}, 32'h1);
      #2;
      reset = 1'b0;
      #1;
      reset_chk("arst");
      #1;
      reset = 1'b1;
      tick();
      wait_ar("post_rst", 32'h3000_0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Global watchdog
   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule : tb_ysyx_23060124_ifu
`default_nettype wire
